// File: rtl/epcs_responder.sv
// EPCS serial-flash slave model: READ, READ STATUS and READ SILICON ID,
// driven from a byte-wide backing memory in the clk_clk domain.
module epcs_responder #(
  parameter int         ADDR_W     = 24,
  parameter logic [7:0] SILICON_ID = 8'h14,
  parameter logic [7:0] STATUS_VAL = 8'h00
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              epcs_dclk,
  input  logic              epcs_sce,
  input  logic              epcs_sdo,
  output logic              epcs_data0,
  output logic              epcs_data0_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_e;

  state_e state_q, state_d;

  logic dclk_m_q, dclk_s_q, dclk_p_q;
  logic sce_m_q, sce_s_q, sce_p_q;
  logic sdo_m_q, sdo_s_q;

  logic [1:0]        warm_q, warm_d;
  logic              armed_q, armed_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        ocnt_q, ocnt_d;
  logic [22:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              rd_dly_q;
  logic [7:0]        next_q, next_d;
  logic [6:0]        out_q, out_d;
  logic              data0_q, data0_d;
  logic              oe_q, oe_d;
  logic              is_read_q, is_read_d;

  logic        rise, fall, start;
  logic [23:0] sh_in;

  assign rise  = dclk_s_q & ~dclk_p_q & ~sce_s_q;
  assign fall  = ~dclk_s_q & dclk_p_q & ~sce_s_q;
  assign start = armed_q & sce_p_q & ~sce_s_q;
  assign sh_in = {shift_q, sdo_s_q};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ocnt_d    = ocnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    next_d    = next_q;
    out_d     = out_q;
    data0_d   = data0_q;
    oe_d      = oe_q;
    is_read_d = is_read_q;
    // sce must be seen high after reset before a select counts
    warm_d    = {warm_q[0], 1'b1};
    armed_d   = armed_q | (warm_q[1] & sce_s_q);

    if (rd_dly_q) next_d = mem_rdata;

    if (state_q != IDLE && sce_s_q) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      data0_d   = 1'b0;
      is_read_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          oe_d    = 1'b0;
          data0_d = 1'b0;
          if (start) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            is_read_d = 1'b0;
          end
        end
        CMD: if (rise) begin
          shift_d   = sh_in[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            ocnt_d    = '0;
            case (sh_in[7:0])
              8'h03: begin
                state_d   = ADDR;
                is_read_d = 1'b1;
              end
              8'h05: begin
                state_d = DATA;
                next_d  = STATUS_VAL;
                oe_d    = 1'b1;
              end
              8'hAB:   state_d = DUMMY;
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: if (rise) begin
          shift_d   = sh_in[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            addr_d    = sh_in[ADDR_W-1:0];
            rd_d      = 1'b1;
            state_d   = DATA;
            oe_d      = 1'b1;
          end
        end
        DUMMY: if (rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            state_d   = DATA;
            next_d    = SILICON_ID;
            oe_d      = 1'b1;
          end
        end
        DATA: begin
          if (fall) begin
            ocnt_d = ocnt_q + 3'd1;
            if (ocnt_q == 3'd0) begin
              out_d   = next_q[6:0];
              data0_d = next_q[7];
            end else begin
              out_d   = {out_q[5:0], 1'b0};
              data0_d = out_q[6];
            end
          end
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (is_read_q) begin
                addr_d = addr_q + ADDR_W'(1);
                rd_d   = 1'b1;
              end
            end
          end
        end
        IGNORE: begin
          oe_d    = 1'b0;
          data0_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      dclk_m_q  <= 1'b0;
      dclk_s_q  <= 1'b0;
      dclk_p_q  <= 1'b0;
      sce_m_q   <= 1'b1;
      sce_s_q   <= 1'b1;
      sce_p_q   <= 1'b1;
      sdo_m_q   <= 1'b0;
      sdo_s_q   <= 1'b0;
      warm_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      ocnt_q    <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      rd_dly_q  <= 1'b0;
      next_q    <= '0;
      out_q     <= '0;
      data0_q   <= 1'b0;
      oe_q      <= 1'b0;
      is_read_q <= 1'b0;
    end else begin
      dclk_m_q  <= epcs_dclk;
      dclk_s_q  <= dclk_m_q;
      dclk_p_q  <= dclk_s_q;
      sce_m_q   <= epcs_sce;
      sce_s_q   <= sce_m_q;
      sce_p_q   <= sce_s_q;
      sdo_m_q   <= epcs_sdo;
      sdo_s_q   <= sdo_m_q;
      warm_q    <= warm_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ocnt_q    <= ocnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      rd_dly_q  <= rd_q;
      next_q    <= next_d;
      out_q     <= out_d;
      data0_q   <= data0_d;
      oe_q      <= oe_d;
      is_read_q <= is_read_d;
    end
  end

  assign epcs_data0    = data0_q;
  assign epcs_data0_oe = oe_q;
  assign mem_addr      = addr_q;
  assign mem_rd        = rd_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_epcs_responder.sv
// Bench for epcs_responder: SPI master tasks, memory model and
// per-cycle checker against expected byte streams and read addresses.
module tb_epcs_responder;
  localparam int HALF = 63;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dclk = 1'b0;
  logic        sce = 1'b1;
  logic        sdo = 1'b0;
  logic        data0, oe, mem_rd, busy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  epcs_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .epcs_dclk     (dclk),
    .epcs_sce      (sce),
    .epcs_sdo      (sdo),
    .epcs_data0    (data0),
    .epcs_data0_oe (oe),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] mem [int];
  int         exp_rd[$];
  logic [7:0] rx_q[$];
  bit         oe_forbid = 1'b1;
  bit         rd_prev = 1'b0;

  function automatic logic [7:0] mem_at(int a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge clk)
    if (mem_rd) mem_rdata <= mem_at(int'(mem_addr));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin
        chk("mem_rd_gap", {31'd0, rd_prev}, 32'd0);
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_rd_unexpected: got addr %h want none",
                   mem_addr);
        end else begin
          chk("mem_addr", {8'd0, mem_addr}, exp_rd.pop_front());
        end
      end
      if (oe_forbid) chk("oe_forbidden", {31'd0, oe}, 32'd0);
      if (!oe) chk("data0_idle", {31'd0, data0}, 32'd0);
    end
    rd_prev = mem_rd;
  end

  task automatic spi_bit(input bit b, input bit clr, output bit r);
    sdo = b;
    #HALF;
    dclk = 1'b1;
    r = data0;
    if (clr) oe_forbid = 1'b0;
    #HALF;
    dclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit clr,
                          output logic [7:0] rx);
    bit r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], clr && (i == 0), r);
      rx[i] = r;
    end
  endtask

  task automatic txn_begin();
    oe_forbid = 1'b1;
    rx_q.delete();
    sce = 1'b0;
    #HALF;
  endtask

  task automatic txn_end(string name);
    #HALF;
    sce = 1'b1;
    #150;
    chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    oe_forbid = 1'b1;
  endtask

  task automatic do_read(input int a, input int n, string name);
    logic [7:0] rx;
    for (int i = 0; i <= n; i++) exp_rd.push_back((a + i) & 24'hFFFFFF);
    txn_begin();
    spi_byte(8'h03, 1'b0, rx);
    spi_byte(a[23:16], 1'b0, rx);
    spi_byte(a[15:8], 1'b0, rx);
    spi_byte(a[7:0], 1'b1, rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, 1'b0, rx);
      rx_q.push_back(rx);
      chk({name, "_rx"}, {24'd0, rx}, {24'd0, mem_at((a + i) & 24'hFFFFFF)});
    end
    txn_end(name);
    chk({name, "_rd_left"}, exp_rd.size(), 32'd0);
    exp_rd.delete();
  endtask

  task automatic do_status(string name);
    logic [7:0] rx;
    txn_begin();
    spi_byte(8'h05, 1'b1, rx);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, 1'b0, rx);
      chk({name, "_rx"}, {24'd0, rx}, 32'h00);
      chk({name, "_oe"}, {31'd0, oe}, 32'd1);
    end
    txn_end(name);
  endtask

  logic [7:0] rx;
  bit         rb;

  initial begin
    mem[32'h10]     = 8'hA5;
    mem[32'h11]     = 8'h3C;
    mem[32'h12]     = 8'hFF;
    mem[32'hFFFFFF] = 8'h11;
    mem[32'h0]      = 8'h22;
    mem[32'h20]     = 8'h5A;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", {31'd0, oe}, 32'd0);
    chk("rst_data0", {31'd0, data0}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #200;

    do_read(32'h10, 3, "read");
    chk("read_lit0", {24'd0, rx_q[0]}, 32'hA5);
    chk("read_lit1", {24'd0, rx_q[1]}, 32'h3C);
    chk("read_lit2", {24'd0, rx_q[2]}, 32'hFF);

    do_read(32'hFFFFFF, 2, "wrap");
    chk("wrap_lit0", {24'd0, rx_q[0]}, 32'h11);
    chk("wrap_lit1", {24'd0, rx_q[1]}, 32'h22);

    do_status("status");

    txn_begin();
    spi_byte(8'hAB, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx);
    spi_byte(8'h00, 1'b1, rx);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, 1'b0, rx);
      chk("id_rx", {24'd0, rx}, 32'h14);
    end
    txn_end("id");

    txn_begin();
    spi_byte(8'h9F, 1'b0, rx);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'hFF, 1'b0, rx);
      chk("unk_rx", {24'd0, rx}, 32'h00);
    end
    chk("unk_busy", {31'd0, busy}, 32'd1);
    txn_end("unk");

    txn_begin();
    spi_byte(8'h03, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, rb);
    sce = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    #150;
    do_read(32'h20, 1, "after_abort");
    chk("after_abort_lit", {24'd0, rx_q[0]}, 32'h5A);

    exp_rd.push_back(32'h10);
    exp_rd.push_back(32'h11);
    txn_begin();
    spi_byte(8'h03, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx);
    spi_byte(8'h10, 1'b1, rx);
    spi_byte(8'h00, 1'b0, rx);
    chk("rstmid_rx", {24'd0, rx}, 32'hA5);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, rb);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_oe", {31'd0, oe}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    oe_forbid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #HALF;
    spi_byte(8'h05, 1'b0, rx);
    spi_byte(8'h00, 1'b0, rx);
    chk("rstmid_no_start", {31'd0, busy}, 32'd0);
    chk("rstmid_rx_quiet", {24'd0, rx}, 32'h00);
    txn_end("rstmid");
    chk("rstmid_rd_left", exp_rd.size(), 32'd0);
    exp_rd.delete();

    do_status("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/epcs_responder.md
EPCS_RESPONDER -- requirements
Module: epcs_responder

Interface
REQ-001 Parameter ADDR_W, default 24: flash byte-address width.
REQ-002 Parameter SILICON_ID, default 8'h14: byte returned by the Read Silicon ID command.
REQ-003 Parameter STATUS_VAL, default 8'h00: byte returned by the Read Status command.
REQ-004 Port list (name direction width meaning) SHALL be:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  reset; synchronous, active-low.
- epcs_dclk  in  1  serial clock from the master, asynchronous to clk_clk.
- epcs_sce  in  1  chip select from the master, active-low.
- epcs_sdo  in  1  master-to-flash serial data.
- epcs_data0  out  1  flash-to-master serial data.
- epcs_data0_oe  out  1  output enable for epcs_data0.
- mem_addr  out  ADDR_W  backing-memory byte address.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data; valid exactly 1 clk after mem_rd.
- busy  out  1  high when state != IDLE.

Function
REQ-005 Synchronizers: epcs_dclk, epcs_sce and epcs_sdo SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized versions.
REQ-006 Edge detection: rise/fall SHALL be detected from the synchronized dclk versus its previous value; edges count only while synchronized sce = 0.
REQ-007 Timing contract: dclk high and low phases are each >= 4 clk_clk periods; behaviour outside this contract is unspecified.
REQ-008 SPI mode: mode 0/3, MSB first. sdo SHALL be sampled on dclk rise; data0 SHALL change only on dclk fall.
REQ-009 States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-010 IDLE -> CMD on a synchronized sce 1->0 transition; the bit counter SHALL clear.
REQ-011 CMD: shift in 8 bits. On the 8th rise, decode:
- 8'h03 -> ADDR.
- 8'h05 -> DATA (load STATUS_VAL).
- 8'hAB -> DUMMY.
- any other value -> IGNORE.
REQ-012 ADDR: shift in 24 bits; the low ADDR_W bits form the address. On the 24th rise, assert mem_rd for 1 clk with mem_addr = address, then enter DATA.
REQ-013 DUMMY: after 24 rises, enter DATA and load SILICON_ID.
REQ-014 DATA, shift register: on the clk after mem_rd, load mem_rdata into the next-byte register.
REQ-015 DATA, byte output: on the first fall of each byte, load the shift register from the next-byte register and drive its bit 7. On each subsequent fall, shift left and drive the new bit 7.
REQ-016 READ (8'h03) prefetch: on the 8th rise of each output byte, address SHALL increment, wrapping from 2^ADDR_W-1 to 0, and mem_rd SHALL pulse at the new address.
REQ-017 Status and ID repeat: Status/ID bytes SHALL repeat indefinitely with no mem_rd.
REQ-018 epcs_data0_oe SHALL be 1 only in DATA; elsewhere epcs_data0_oe = 0 and epcs_data0 = 0.
REQ-019 Deselect: synchronized sce = 1 in any state SHALL force IDLE on the next clk, with oe = 0 and no further mem_rd. A partially shifted command or address SHALL be discarded.
REQ-020 IGNORE SHALL hold (oe = 0) until deselect.
REQ-021 Simultaneous events: if sce rises on the same clk as a dclk edge, the deselect SHALL win and the edge SHALL be ignored.
REQ-022 mem_rd SHALL never be asserted on two consecutive clks.

Reset
REQ-023 Reset values while reset_reset_n = 0 at a clk edge:
- state = IDLE.
- epcs_data0 = 0, epcs_data0_oe = 0.
- mem_rd = 0, mem_addr = 0, busy = 0.
- synchronizer flops: dclk = 0, sce = 1, sdo = 0.
- bit counter = 0.
REQ-024 Reset mid-transfer SHALL abort immediately.
REQ-025 Reset release with sce low: after release, a new transaction SHALL start only after sce has been seen high and then low.

Verification
REQ-026 Read: send 8'h03, 24'h000010, then 3 bytes of clocks; memory holds 0x10->A5, 0x11->3C, 0x12->FF -> master receives A5 3C FF; mem_addr pulses 0x10, 0x11, 0x12, 0x13.
REQ-027 Address wrap: READ at 24'hFFFFFF with mem[FFFFFF]=11, mem[0]=22 -> master receives 11 22; second mem_addr = 0.
REQ-028 Status: 8'h05 then 2 bytes -> master receives 00 00; mem_rd never asserted; oe = 1 only after the 8th command rise.
REQ-029 Silicon ID: 8'hAB + 3 dummy bytes + 2 bytes -> master receives 14 14.
REQ-030 Abort/unknown command:
- 8'h9F -> oe stays 0 for the whole transaction.
- Separately, raise sce after 12 address bits -> busy = 0 within 4 clks; the next READ decodes correctly.
REQ-031 Reset mid-DATA: assert reset_reset_n = 0 for 1 clk during DATA -> oe = 0 and busy = 0 at the next clk; with sce still low, no output until a fresh sce high->low transition.
